// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID->EX hazard sequencer: RAW stall, redirect flush, dmem freeze, stall counter.
// Optional operand forwarding selects under `HAZARD_FWD_EN.
module hazard_ctrl #(
  parameter int RW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs1,
  input  logic             id_rs1_used,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_rs2_used,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_wen,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_if_id,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rd;
    logic          wen;
    logic          is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FREEZE = 2'd2,
    HZ_FLUSH  = 2'd3
  } hz_t;

  sb_entry_t sb_ex, sb_mem, sb_wb;
  sb_entry_t id_entry;
  hz_t       action, hz_q;
  logic      raw, issue;
  logic      m_ex_a, m_ex_b, m_mem_a, m_mem_b;

  function automatic logic match(input sb_entry_t e, input logic used, input logic [RW-1:0] rs);
    return used & e.valid & e.wen & (e.rd == rs);
  endfunction

  assign m_ex_a  = match(sb_ex,  id_rs1_used, id_rs1);
  assign m_ex_b  = match(sb_ex,  id_rs2_used, id_rs2);
  assign m_mem_a = match(sb_mem, id_rs1_used, id_rs1);
  assign m_mem_b = match(sb_mem, id_rs2_used, id_rs2);

`ifdef HAZARD_FWD_EN
  // Only a load sitting in EX cannot be forwarded in time.
  assign raw = id_valid & sb_ex.is_load & (m_ex_a | m_ex_b);
`else
  assign raw = id_valid & (m_ex_a | m_ex_b | m_mem_a | m_mem_b);
`endif

  assign id_entry = '{valid: 1'b1, rd: id_rd, wen: id_reg_wen, is_load: id_is_load};

  always_comb begin
    action      = HZ_RUN;
    stall_if    = 1'b0;
    stall_id    = 1'b0;
    bubble_ex   = 1'b0;
    flush_if_id = 1'b0;
    if (mem_busy) begin
      action   = HZ_FREEZE;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (ex_redirect) begin
      action      = HZ_FLUSH;
      flush_if_id = 1'b1;
      bubble_ex   = 1'b1;
    end else if (raw) begin
      action    = HZ_STALL;
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign issue = (action == HZ_RUN) & id_valid;

  // Scoreboard shifts only when the pipe moves; a frozen cycle holds every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else if (!mem_busy) begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      sb_ex  <= issue ? id_entry : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_q      <= HZ_RUN;
      stall_cnt <= '0;
    end else begin
      hz_q <= action;
      if (action != HZ_RUN && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign hz_state = hz_q;

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_q, fwd_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else if (!mem_busy) begin
      if (issue) begin
        fwd_a_q <= m_ex_a ? 2'b01 : (m_mem_a ? 2'b10 : 2'b00);
        fwd_b_q <= m_ex_b ? 2'b01 : (m_mem_b ? 2'b10 : 2'b00);
      end else begin
        fwd_a_q <= 2'b00;
        fwd_b_q <= 2'b00;
      end
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
`else
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  // WB never hazards (write-before-read regfile); it is tracked but not compared.
  logic unused_sb;
  assign unused_sb = ^{sb_wb, sb_mem.is_load, sb_ex.is_load};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - Scoreboard bench for hazard_ctrl with directed vectors.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_reg_wen = 1'b0, id_is_load = 1'b0;
  logic       ex_redirect = 1'b0, mem_busy = 1'b0;
  logic       stall_if, stall_id, bubble_ex, flush_if_id;
  logic [1:0] fwd_a, fwd_b, hz_state;
  logic [3:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.RW(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_wen(id_reg_wen), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_if(stall_if), .stall_id(stall_id),
    .bubble_ex(bubble_ex), .flush_if_id(flush_if_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .hz_state(hz_state), .stall_cnt(stall_cnt)
  );

  typedef struct {
    int         tag;
    logic       st, bub, fl;
    logic [1:0] fa, fb, hz;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;
  bit   done   = 1'b0;

  logic       n_v, n_u1, n_u2, n_wen, n_ld;
  logic [3:0] n_rs1, n_rs2, n_rd;

  task automatic check(input int tag, input string f, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %0h expected %0h", tag, f, act, req);
    end
  endtask

  task automatic set_id(input logic v, input logic [3:0] rs1, input logic u1,
                        input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                        input logic wen, input logic ld);
    n_v = v; n_rs1 = rs1; n_u1 = u1; n_rs2 = rs2; n_u2 = u2;
    n_rd = rd; n_wen = wen; n_ld = ld;
  endtask

  // One cycle: apply staged ID + controls just after the edge, queue the expected response.
  task automatic cyc(input logic r, input logic redir, input logic busy, input logic chk,
                     input logic st, input logic bub, input logic fl,
                     input logic [1:0] fa, input logic [1:0] fb,
                     input logic [1:0] hz, input logic [3:0] cnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_redirect = redir; mem_busy = busy;
    id_valid = n_v; id_rs1 = n_rs1; id_rs1_used = n_u1; id_rs2 = n_rs2;
    id_rs2_used = n_u2; id_rd = n_rd; id_reg_wen = n_wen; id_is_load = n_ld;
    if (chk) begin
      tag_n++;
      e.tag = tag_n; e.st = st; e.bub = bub; e.fl = fl;
      e.fa = fa; e.fb = fb; e.hz = hz; e.cnt = cnt;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(e.tag, "stall_if",    4'(stall_if),    4'(e.st));
        check(e.tag, "stall_id",    4'(stall_id),    4'(e.st));
        check(e.tag, "bubble_ex",   4'(bubble_ex),   4'(e.bub));
        check(e.tag, "flush_if_id", 4'(flush_if_id), 4'(e.fl));
        check(e.tag, "fwd_a",       4'(fwd_a),       4'(e.fa));
        check(e.tag, "fwd_b",       4'(fwd_b),       4'(e.fb));
        check(e.tag, "hz_state",    4'(hz_state),    4'(e.hz));
        check(e.tag, "stall_cnt",   stall_cnt,       e.cnt);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    // T1: reset state, then reset in the middle of a load-use stall
    do_reset();
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 1, 1, 0, 0, 3, 1, 1);                          // LW r3
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 3, 1, 1, 1, 4, 1, 0);                          // SUB r4,r3,r1
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);

    // T2: ADD r3 then SUB r4,r3,r1
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
`ifdef HAZARD_FWD_EN
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b01, 2'b00, 2'd0, 4'd0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
`else
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd1, 4'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1, 4'd2);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd2);
`endif

    // T3: LW r5 then ADD r6,r5,r5
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd0, 4'd0);
`ifdef HAZARD_FWD_EN
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1, 4'd1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b10, 2'd0, 4'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd1);
`else
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd1, 4'd1);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1, 4'd2);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd2);
`endif

    // T4: redirect beats RAW; squashed SUB r4 must not create a hazard on r4
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 3, 1, 1, 1, 4, 1, 0);
    cyc(0, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 4, 1, 4, 1, 7, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd3, 4'd1);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd1);

    // T5: mem_busy for 3 cycles masks ex_redirect, then one FLUSH
    do_reset();
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 1, 1, 2, 1, 8, 1, 0);
    cyc(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    cyc(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd2, 4'd1);
    cyc(0, 1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 2'd2, 4'd2);
    cyc(0, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 2'd2, 4'd3);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd3, 4'd4);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd4);

    // T7: unused source, WB producer, self-reference, r0 is a real register
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0);                          // ADD r3
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 3, 0, 3, 0, 0, 0, 0);                          // reads nothing
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 3, 1, 3, 1, 6, 1, 0);                          // ADD r3 now in WB
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 5, 1, 0, 0, 5, 1, 0);                          // r5 <= r5
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 9, 1, 0, 0, 0, 1, 1);                          // LW r0
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(1, 0, 1, 0, 0, 2, 1, 0);                          // reads r0
    cyc(0, 0, 0, 1, 1, 1, 0, 2'b00, 2'b00, 2'd0, 4'd0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd1, 4'd1);

    // T6: counter saturation (CNT_W=4 -> all-ones is 15)
    do_reset();
    for (int k = 0; k < 19; k++)
      cyc(0, 0, 1, 1, 1, 0, 0, 2'b00, 2'b00, (k == 0) ? 2'd0 : 2'd2,
          (k > 15) ? 4'd15 : 4'(k));
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd2, 4'd15);
    cyc(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0, 4'd15);

    @(posedge clk);
    @(negedge clk);
    #1;
    check(0, "queue_drain", 4'(exp_q.size()), 4'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
